// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Round-robin on ties, registered memory strobe, watchdog abort.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    localparam logic       FETCH = 1'b0;
    localparam logic [7:0] TMAX  = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       grant_i;
    logic       grant_d;
    logic       done;
    logic       abort;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx = D_WAIT;
                end else if (grant_i) begin
                    state_nx = I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                if (done || abort) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // An ack in flight blocks arbitration, leaving one bubble per access.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!(if_ack || d_ack)) begin
                    if (if_req && d_req) begin
                        grant_d = (last_grant == FETCH);
                        grant_i = (last_grant != FETCH);
                    end else begin
                        grant_d = d_req;
                        grant_i = if_req;
                    end
                end
            end
            I_WAIT, D_WAIT: begin
                done  = mem_ready;
                abort = !mem_ready && (wait_cnt == TMAX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            wait_cnt   <= '0;
            last_grant <= FETCH;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            if (grant_d) begin
                mem_req    <= 1'b1;
                mem_we     <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                wait_cnt   <= '0;
                last_grant <= ~FETCH;
            end else if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                wait_cnt   <= '0;
                last_grant <= FETCH;
            end else if (done || abort) begin
                mem_req <= 1'b0;
                err     <= abort;
                if (state == I_WAIT) begin
                    if_ack   <= 1'b1;
                    if_rdata <= abort ? '0 : mem_rdata;
                end else begin
                    d_ack <= 1'b1;
                    if (abort) begin
                        d_rdata <= '0;
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for round-robin ties and reset during an access.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // flags = {if_ack, d_ack, err, stall_if, stall_mem, mem_req}
    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        rdy;
        logic [31:0] rdata;
        logic [5:0]  flags;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic we, input logic [31:0] da,
        input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
        input logic [5:0] fl, input logic mwe, input logic [31:0] ma,
        input logic [31:0] mwd, input logic [31:0] ird,
        input logic [31:0] drd);
        vec_t t;
        t.rst_n = r;   t.if_req = ir; t.if_addr = ia;
        t.d_req = dr;  t.d_we = we;   t.d_addr = da;
        t.d_wdata = wd; t.rdy = rdy;  t.rdata = rd;
        t.flags = fl;  t.mwe = mwe;   t.maddr = ma;
        t.mwdata = mwd; t.ird = ird;  t.drd = drd;
        return t;
    endfunction

    function automatic logic [134:0] outs();
        return {if_ack, d_ack, err, stall_if, stall_mem, mem_req,
                mem_we, mem_addr, mem_wdata, if_rdata, d_rdata};
    endfunction

    task automatic check(input string name, input logic [134:0] got,
                         input logic [134:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got,
                          input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    endtask

    localparam logic [31:0] BEEF = 32'hDEADBEEF;
    localparam logic [31:0] SW   = 32'h12345678;
    localparam logic [31:0] FOOD = 32'h0BADF00D;
    localparam logic [31:0] CAFE = 32'hCAFEF00D;

    int grants[$];
    int owner;
    int wc;
    int acks;
    logic prev;

    initial begin
        rst_n = 0;
        idle_inputs();

        // reset and idle
        v.push_back(mk(0,0,0,0,0,0,0,0,0, 6'b000000,0,0,0,0,0));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,0,0,0,0,0));
        // lw zero-wait at 0x40
        v.push_back(mk(1,0,0,1,0,32'h40,0,0,0, 6'b000010,0,0,0,0,0));
        v.push_back(mk(1,0,0,1,0,32'h40,0,1,BEEF, 6'b000011,0,32'h40,0,0,0));
        v.push_back(mk(1,0,0,1,0,32'h40,0,0,0, 6'b010000,0,32'h40,0,0,BEEF));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,0,32'h40,0,0,BEEF));
        // sw with 3 wait cycles; ready lands on the timeout cycle
        v.push_back(mk(1,0,0,1,1,32'h80,SW,0,0, 6'b000010,0,32'h40,0,0,BEEF));
        v.push_back(mk(1,0,0,1,1,32'h80,SW,0,0, 6'b000011,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,0,0,1,1,32'h80,SW,0,0, 6'b000011,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,0,0,1,1,32'h80,SW,0,0, 6'b000011,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,0,0,1,1,32'h80,SW,1,32'hBAD0BAD0,
                       6'b000011,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,0,0,1,1,32'h80,SW,0,0, 6'b010000,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,1,32'h80,SW,0,BEEF));
        // fetch zero-wait at 0x200
        v.push_back(mk(1,1,32'h200,0,0,0,0,0,0, 6'b000100,1,32'h80,SW,0,BEEF));
        v.push_back(mk(1,1,32'h200,0,0,0,0,1,FOOD,
                       6'b000101,0,32'h200,SW,0,BEEF));
        v.push_back(mk(1,1,32'h200,0,0,0,0,0,0,
                       6'b100000,0,32'h200,SW,FOOD,BEEF));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,0,32'h200,SW,FOOD,BEEF));
        // fetch timeout at 0x100
        v.push_back(mk(1,1,32'h100,0,0,0,0,0,0,
                       6'b000100,0,32'h200,SW,FOOD,BEEF));
        for (int k = 0; k < 4; k++)
            v.push_back(mk(1,1,32'h100,0,0,0,0,0,0,
                           6'b000101,0,32'h100,SW,FOOD,BEEF));
        v.push_back(mk(1,1,32'h100,0,0,0,0,0,0,
                       6'b101000,0,32'h100,SW,0,BEEF));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,0,32'h100,SW,0,BEEF));
        // fetch with ready in the 4th cycle: no err
        v.push_back(mk(1,1,32'h300,0,0,0,0,0,0,
                       6'b000100,0,32'h100,SW,0,BEEF));
        for (int k = 0; k < 3; k++)
            v.push_back(mk(1,1,32'h300,0,0,0,0,0,0,
                           6'b000101,0,32'h300,SW,0,BEEF));
        v.push_back(mk(1,1,32'h300,0,0,0,0,1,CAFE,
                       6'b000101,0,32'h300,SW,0,BEEF));
        v.push_back(mk(1,1,32'h300,0,0,0,0,0,0,
                       6'b100000,0,32'h300,SW,CAFE,BEEF));
        v.push_back(mk(1,0,0,0,0,0,0,0,0, 6'b000000,0,32'h300,SW,CAFE,BEEF));

        repeat (2) @(posedge clk);
        for (int i = 0; i < v.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = v[i].rst_n;   if_req = v[i].if_req;
            if_addr = v[i].if_addr; d_req = v[i].d_req;
            d_we = v[i].d_we;     d_addr = v[i].d_addr;
            d_wdata = v[i].d_wdata; mem_ready = v[i].rdy;
            mem_rdata = v[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {v[i].flags, v[i].mwe, v[i].maddr, v[i].mwdata,
                   v[i].ird, v[i].drd});
        end

        // ties with a 1-wait memory alternate, data first here
        owner = -1; wc = 0; acks = 0; prev = 0;
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_addr = 32'h500; d_we = 0; d_wdata = 0;
        mem_ready = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(posedge clk);
            #1;
            if (if_ack || d_ack) begin
                acks++;
                check1($sformatf("tie_ack%0d_if", acks), if_ack, owner == 0);
                check1($sformatf("tie_ack%0d_d", acks), d_ack, owner == 1);
            end
            if (mem_req && !prev) begin
                owner = (mem_addr == 32'h500) ? 1 : 0;
                grants.push_back(owner);
                wc = 0;
            end else if (mem_req) begin
                wc++;
            end
            mem_ready = mem_req && (wc == 1);
            mem_rdata = 32'h1000 + c;
            prev = mem_req;
        end
        checks++;
        if (acks != 4) begin
            errors++;
            $display("FAIL tie_acks: got %0d want 4", acks);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (grants.size() <= k || grants[k] != ((k % 2 == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL tie_grant%0d: got %0d want %0d", k,
                         (grants.size() > k) ? grants[k] : -1,
                         (k % 2 == 0) ? 1 : 0);
            end
        end
        if_req = 0; d_req = 0; mem_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 0;
        repeat (2) @(posedge clk);

        // reset while a load is waiting on memory
        #1;
        d_req = 1; d_addr = 32'h600; d_we = 0; mem_rdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        check1("rst_pre_mem_req", mem_req, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 0; if_req = 1; if_addr = 32'h700;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_outs%0d", k),
                  {1'b0, if_ack, d_ack, err, mem_req, mem_we,
                   mem_addr, mem_wdata, if_rdata, d_rdata},
                  135'd0);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
        check("rst_first_grant", {102'd0, mem_req, mem_addr},
              {102'd0, 1'b1, 32'h600});
        mem_ready = 1;
        @(posedge clk);
        #1;
        check("rst_first_ack", {101'd0, if_ack, d_ack, d_rdata},
              {101'd0, 1'b0, 1'b1, 32'h55AA55AA});
        if_req = 0; d_req = 0; mem_ready = 0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined MIPS core. It serialises requests, drives the memory handshake, returns read data and a one-cycle acknowledge to the winning stage, and produces per-stage stall signals for the hazard/stall logic. A watchdog aborts any access the memory does not complete within a bounded number of cycles.

## Interface

- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles mem_req may stay high awaiting mem_ready (legal range 2..255)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse, fetch done
- if_rdata  out  DW  fetched instruction, valid with if_ack, held afterwards
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse, data access done
- d_rdata  out  DW  load data, valid with d_ack on loads, held afterwards
- err  out  1  one-cycle pulse coincident with the ack of an aborted access
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- mem_req  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_ready  in  1  memory completes current access this cycle
- mem_rdata  in  DW  memory read data, valid with mem_ready

## Operation

- States: IDLE, I_WAIT, D_WAIT.
- IDLE: grant is decided on sampled requests at the clock edge.
  - Only d_req: grant data. Only if_req: grant fetch.
  - Both: round-robin. Grant goes to the requester not granted last (last_grant flag). After reset, last_grant = FETCH, so data wins the first tie.
  - On grant: capture addr, we, wdata into mem_* regs. Set mem_req=1 and update last_grant. Go to the owner's WAIT state. Fetch grants force mem_we=0.
- I_WAIT / D_WAIT: mem_req and mem_* held stable.
  - mem_ready=1 sampled: mem_req→0. Pulse owner's ack next cycle. Load mem_rdata into if_rdata (fetch) or d_rdata (load only; stores leave d_rdata unchanged). Return to IDLE.
- Watchdog: wait_cnt (8 bits) clears on grant and increments each WAIT cycle without mem_ready.
  - When wait_cnt = TIMEOUT-1 and mem_ready=0: abort. mem_req→0, pulse owner's ack and err, rdata register of the owner loads 0, return to IDLE.
  - mem_ready in that same cycle takes precedence: normal completion, no err.
- Requester dropping req mid-transaction: the access still completes and the ack still pulses. Requesters must hold req until ack; the arbiter does not check this.
- Ack and new grant never share a cycle. The state after completion is always IDLE, giving one arbitration bubble.
- Reset (rst_n=0 at an edge, any state): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=d_ack=err=0, if_rdata=d_rdata=0, wait_cnt=0, last_grant=FETCH. In-flight access is abandoned without ack. Requests during reset are ignored.

## Timing

- Cycle 0: req sampled in IDLE. Cycle 1: mem_req=1.
- mem_ready high in cycle k≥1: ack and rdata in cycle k+1, state IDLE in k+1.
- Minimum req→ack latency: 2 cycles.
- Back-to-back accesses: at most one access per 3 cycles with zero-wait memory.
- Abort: mem_req high for exactly TIMEOUT cycles, ack+err in the following cycle.
- stall_* are combinational and drop in the ack cycle, so the stage advances on that edge.

## Test plan

- Single lw, zero-wait: d_req=1, d_we=0, d_addr=0x40, mem_ready on first mem_req cycle, mem_rdata=0xDEADBEEF -> mem_req only in cycle 1, d_ack and d_rdata=0xDEADBEEF in cycle 2, stall_mem=1 in cycles 0–1.
- Tie after reset: if_req and d_req both held, 1-wait memory -> grant order data, fetch, data, fetch. No ack ever lacks a prior mem_req for that owner.
- sw with 3 wait cycles: d_we=1, d_wdata=0x12345678 -> mem_we=1 and wdata stable 4 cycles, d_ack next cycle, d_rdata unchanged, if_ack never pulses.
- Timeout: TIMEOUT=4, fetch, mem_ready never asserted -> mem_req high 4 cycles, then if_ack=err=1 with if_rdata=0, state IDLE. Repeat with mem_ready in 4th cycle -> err=0.
- Reset mid-access: rst_n low during D_WAIT -> next cycle all outputs at reset values, no d_ack. After release, a pending tie grants data first.
